id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- Operand-collection stage between instruction decode and the ALU/execute stage.
- Accepts one decoded instruction over a valid/ready handshake and drives source addresses to the register file, whose read data is registered at posedge (1-cycle latency).
- Applies EX/WB forwarding and the register-0 rule, and stalls on load-use hazards.
- Presents resolved operands downstream over a valid/ready handshake.

Parameters:
CTRL_W, 16, width of opaque decoded-control bundle passed through unchanged
STALL_CNT_W, 16, width of saturating load-use stall counter

Ports:
CLK  input  1  clock; all state changes on posedge
RESET_N  input  1  asynchronous, active-low reset
in_valid  input  1  decoded instruction available
in_ready  output  1  stage can accept; combinational from state and out_ready
in_rs  input  5  source register 1
in_rt  input  5  source register 2
in_rd  input  5  destination register, passed through
in_ctrl  input  CTRL_W  decoded control, passed through
r_addr1  output  5  register file read address 1
r_addr2  output  5  register file read address 2
read1  input  32  register file read data 1 (valid 1 cycle after address)
read2  input  32  register file read data 2
ex_wr  input  1  instruction in EX will write a register
ex_is_load  input  1  instruction in EX is a load (data not yet available)
ex_waddr  input  5  EX destination register
ex_data  input  32  EX ALU result
wb_wr  input  1  writeback write enable (same cycle as register file reg_wr)
wb_waddr  input  5  writeback destination
wb_data  input  32  writeback data
out_valid  output  1  operands valid
out_ready  input  1  execute stage accepts
out_op1  output  32  resolved operand 1
out_op2  output  32  resolved operand 2
out_rd  output  5  passed-through destination
out_ctrl  output  CTRL_W  passed-through control
stall_cnt  output  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- States: IDLE, ADDR, DATA, OUT.
- Reset (RESET_N low, async):
  - State goes to IDLE; the in-flight instruction is dropped.
  - out_valid=0, out_op1=out_op2=0, out_rd=0, out_ctrl=0, stall_cnt=0.
  - Latched rs/rt=0, so r_addr1=r_addr2=0.
- in_ready = (state==IDLE) || (state==OUT && out_ready).
- Accept = in_valid && in_ready:
  - Latch rs, rt, rd, ctrl; next state ADDR.
  - r_addr1/r_addr2 drive the latched rs/rt continuously until the next accept.
- ADDR: unconditional -> DATA. The register file samples the addresses at this edge.
- DATA:
  - Hazard = ex_wr && ex_is_load && ex_waddr!=0 && (ex_waddr==rs || ex_waddr==rt).
  - Hazard -> remain in DATA and increment stall_cnt, saturating at all-ones. The register file re-reads each cycle, so later writebacks are picked up.
  - No hazard -> capture operands, set out_valid=1, go to OUT.
- Operand resolution per source s, in priority order:
  1. s==0 -> 0.
  2. ex_wr && !ex_is_load && ex_waddr==s -> ex_data.
  3. wb_wr && wb_waddr==s -> wb_data. Covers the register file negedge write not yet visible in the registered read.
  4. Otherwise the register file read data.
- OUT:
  - out_valid=1; out_* held stable while !out_ready.
  - While held, if wb_wr && wb_waddr!=0 && wb_waddr matches rs (rt), update out_op1 (out_op2) with wb_data. Both update if rs==rt.
  - out_ready && in_valid -> accept new instruction, out_valid=0 next cycle, -> ADDR.
  - out_ready && !in_valid -> out_valid=0, -> IDLE.
- Latency: accept at edge T -> out_valid high after edge T+2 (no stall). Throughput: one instruction per 3 cycles.
- out_rd and out_ctrl update only at capture.
- stall_cnt is never cleared except by reset.

Test Plan:
- Reset then no-hazard read: reg5=7, reg6=9 preloaded; accept rs=5, rt=6, rd=3 at T -> out_valid after T+2, out_op1=7, out_op2=9, out_rd=3; in_ready=1 in IDLE.
- Register-0 rule: rs=0 with register file returning 0xDEADBEEF on read1, and ex_wr=1, ex_waddr=0, ex_data=0x55 -> out_op1=0.
- Forward priority: rs=4 in DATA with ex_wr=1, ex_waddr=4, ex_data=0x11 and wb_wr=1, wb_waddr=4, wb_data=0x22 -> out_op1=0x11; EX inactive -> 0x22.
- Load-use stall: rt=8, ex_is_load=1, ex_waddr=8 for 2 cycles -> DATA held 2 cycles, stall_cnt=2. Then wb writes reg8=0x99 -> out_op2=0x99, out_valid latency T+4.
- Backpressure snoop: out_ready=0 in OUT with rs=rt=2; wb_wr reg2=0x1234 -> out_op1=out_op2=0x1234, other outputs unchanged; then out_ready=1 with in_valid=0 -> out_valid=0, IDLE.
- Async reset in DATA: RESET_N low mid-cycle -> out_valid=0, stall_cnt=0, r_addr1=r_addr2=0 immediately, no output after release.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// Operand collection between decode and execute: reg-file read, EX/WB forwarding, load-use stall.
// Latency: accept at edge T -> out_valid after T+2, plus one cycle per load-use stall; one instr per 3 cycles.
// Backpressure: outputs hold while out_ready is low; in_ready only in IDLE or when OUT drains.
module id_ex_operand_stage #(
    parameter int CTRL_W      = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs,
    input  logic [4:0]             in_rt,
    input  logic [4:0]             in_rd,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic [4:0]             r_addr1,
    output logic [4:0]             r_addr2,
    input  logic [31:0]            read1,
    input  logic [31:0]            read2,
    input  logic                   ex_wr,
    input  logic                   ex_is_load,
    input  logic [4:0]             ex_waddr,
    input  logic [31:0]            ex_data,
    input  logic                   wb_wr,
    input  logic [4:0]             wb_waddr,
    input  logic [31:0]            wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_op1,
    output logic [31:0]            out_op2,
    output logic [4:0]             out_rd,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, OUT} state_t;

    state_t             state, state_nxt;
    logic [4:0]         rs_q, rt_q, rd_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               accept;
    logic               hazard;
    logic [31:0]        op1_res, op2_res;

    // Register 0 wins, then a non-load EX result, then the WB value (the
    // reg file's negedge write is not yet visible in its registered read).
    function automatic logic [31:0] resolve(
        input logic [4:0]  src,
        input logic [31:0] rf_dat,
        input logic        fwd_ex_wr,
        input logic        fwd_ex_load,
        input logic [4:0]  fwd_ex_addr,
        input logic [31:0] fwd_ex_dat,
        input logic        fwd_wb_wr,
        input logic [4:0]  fwd_wb_addr,
        input logic [31:0] fwd_wb_dat
    );
        logic [31:0] res;
        res = rf_dat;
        if (src == 5'd0)
            res = 32'd0;
        else if (fwd_ex_wr && !fwd_ex_load && fwd_ex_addr == src)
            res = fwd_ex_dat;
        else if (fwd_wb_wr && fwd_wb_addr == src)
            res = fwd_wb_dat;
        return res;
    endfunction

    assign in_ready = (state == IDLE) || (state == OUT && out_ready);
    assign accept   = in_valid && in_ready;
    assign r_addr1  = rs_q;
    assign r_addr2  = rt_q;

    assign hazard = ex_wr && ex_is_load && (ex_waddr != 5'd0) &&
                    ((ex_waddr == rs_q) || (ex_waddr == rt_q));

    always_comb begin
        op1_res = resolve(rs_q, read1, ex_wr, ex_is_load, ex_waddr, ex_data,
                          wb_wr, wb_waddr, wb_data);
        op2_res = resolve(rt_q, read2, ex_wr, ex_is_load, ex_waddr, ex_data,
                          wb_wr, wb_waddr, wb_data);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADDR;
            ADDR:    state_nxt = DATA;
            DATA:    if (!hazard) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = in_valid ? ADDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rs_q   <= 5'd0;
            rt_q   <= 5'd0;
            rd_q   <= 5'd0;
            ctrl_q <= '0;
        end else if (accept) begin
            rs_q   <= in_rs;
            rt_q   <= in_rt;
            rd_q   <= in_rd;
            ctrl_q <= in_ctrl;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid <= 1'b0;
            out_op1   <= 32'd0;
            out_op2   <= 32'd0;
            out_rd    <= 5'd0;
            out_ctrl  <= '0;
            stall_cnt <= '0;
        end else if (state == DATA) begin
            if (hazard) begin
                if (stall_cnt != '1)
                    stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end else begin
                out_valid <= 1'b1;
                out_op1   <= op1_res;
                out_op2   <= op2_res;
                out_rd    <= rd_q;
                out_ctrl  <= ctrl_q;
            end
        end else if (state == OUT) begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                // Keep held operands coherent with writebacks landing meanwhile.
                if (wb_wr && wb_waddr != 5'd0 && wb_waddr == rs_q)
                    out_op1 <= wb_data;
                if (wb_wr && wb_waddr != 5'd0 && wb_waddr == rt_q)
                    out_op2 <= wb_data;
            end
        end
    end

endmodule
